// File: rtl/systolic_matmul_core.sv
// Output-stationary NxN systolic multiplier: C = A x B with skewed row/column feeders.
// Latency: 3N-2 cycles from accept edge to the o_validResult pulse.
// Backpressure: o_ready is high only in IDLE; requests while busy are ignored.
module systolic_matmul_core #(
  parameter int N      = 4,
  parameter int W      = 8,
  parameter int ACCW   = 2*W + $clog2(N),
  parameter int SIGNED = 0
) (
  input  logic                             i_clk,
  input  logic                             i_arst,
  input  logic [N-1:0][N-1:0][W-1:0]       i_a,
  input  logic [N-1:0][N-1:0][W-1:0]       i_b,
  input  logic                             i_validInput,
  output logic                             o_ready,
  output logic [N-1:0][N-1:0][ACCW-1:0]    o_c,
  output logic                             o_validResult
);

  localparam int              CW   = $clog2(3*N);
  // Counter value seen just before the final MAC edge E(3N-2).
  localparam logic [CW-1:0]   LAST = CW'(3*N-3);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                          state_q, state_d;
  logic [CW-1:0]                   cnt_q;
  logic                            accept, last;

  // Captured operands the feeders index into; only written on the accept edge.
  logic [N-1:0][N-1:0][W-1:0]      a_q, b_q;
  logic [N-1:0][W-1:0]             feed_a, feed_b;
  // a_pipe[i][j] carries PE(i,j)'s a operand to PE(i,j+1); b_pipe[i][j] to PE(i+1,j).
  logic [N-1:0][N-2:0][W-1:0]      a_pipe;
  logic [N-2:0][N-1:0][W-1:0]      b_pipe;
  logic [N-1:0][N-1:0][W-1:0]      a_in, b_in;
  logic [N-1:0][N-1:0][ACCW-1:0]   acc, acc_nxt;

  // Full 2W-bit product, extended to accumulator width per operand signedness.
  function automatic logic [ACCW-1:0] mul_ext(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] ps;
    logic        [2*W-1:0] pu;
    ps = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
    pu = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    if (SIGNED != 0) return {{(ACCW-2*W){ps[2*W-1]}}, ps};
    else             return {{(ACCW-2*W){1'b0}}, pu};
  endfunction

  // Next-state and handshake decode: accept from IDLE, finish on the last MAC edge.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    o_ready = 1'b0;
    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_validInput) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == LAST) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Run cycle counter: 0 after accept, advances on every RUN edge.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst)                cnt_q <= '0;
    else if (accept)           cnt_q <= '0;
    else if (state_q == RUN)   cnt_q <= cnt_q + CW'(1);
  end

  // Skew feeders: row i / column j emit element k when cnt == index + k, else zero.
  always_comb begin
    feed_a = '0;
    feed_b = '0;
    if (state_q == RUN) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(cnt_q) == i + k) begin
            feed_a[i] = a_q[i][k];
            feed_b[i] = b_q[k][i];
          end
        end
      end
    end
  end

  // PE operand routing and the multiply-accumulate for every grid position.
  always_comb begin
    a_in = '0;
    b_in = '0;
    for (int i = 0; i < N; i++) begin
      a_in[i][0] = feed_a[i];
      b_in[0][i] = feed_b[i];
      for (int j = 1; j < N; j++) begin
        a_in[i][j] = a_pipe[i][j-1];
        b_in[j][i] = b_pipe[j-1][i];
      end
    end
    acc_nxt = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc_nxt[i][j] = acc[i][j] + mul_ext(a_in[i][j], b_in[i][j]);
      end
    end
  end

  // Datapath: capture on accept, accumulate and shift while running, publish on the last edge.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      a_q           <= '0;
      b_q           <= '0;
      a_pipe        <= '0;
      b_pipe        <= '0;
      acc           <= '0;
      o_c           <= '0;
      o_validResult <= 1'b0;
    end else begin
      o_validResult <= last;
      if (accept) begin
        a_q    <= i_a;
        b_q    <= i_b;
        a_pipe <= '0;
        b_pipe <= '0;
        acc    <= '0;
      end else if (state_q == RUN) begin
        acc <= acc_nxt;
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N-1; j++) begin
            a_pipe[i][j] <= a_in[i][j];
            b_pipe[j][i] <= b_in[j][i];
          end
        end
        if (last) o_c <= acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_systolic_matmul_core.sv
// Bench for systolic_matmul_core: unsigned and signed instances driven in lockstep.
// Each accept pushes reference products to per-instance queues; completions pop and compare.
// A cycle model of ready/valid/held result is checked after every clock edge.
module tb_systolic_matmul_core;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int ACCW = 2*W + $clog2(N);
  localparam int LAT  = 3*N - 2;

  typedef logic [N-1:0][N-1:0][W-1:0]    mat_t;
  typedef logic [N-1:0][N-1:0][ACCW-1:0] mat_c_t;

  logic   clk   = 1'b0;
  logic   arst  = 1'b0;
  logic   valid = 1'b0;
  mat_t   a     = '0;
  mat_t   b     = '0;
  logic   rdy_u, rdy_s, vld_u, vld_s;
  mat_c_t c_u, c_s;

  int     n_assert  = 0;
  int     n_fail    = 0;
  int     cyc       = 0;
  int     rem       = 0;
  int     pulse_cnt = 0;
  mat_c_t exp_cu    = '0;
  mat_c_t exp_cs    = '0;
  mat_c_t q_u[$];
  mat_c_t q_s[$];

  always #5 clk = ~clk;

  systolic_matmul_core #(.N(N), .W(W), .ACCW(ACCW), .SIGNED(0)) dut_u (
    .i_clk(clk), .i_arst(arst), .i_a(a), .i_b(b), .i_validInput(valid),
    .o_ready(rdy_u), .o_c(c_u), .o_validResult(vld_u));

  systolic_matmul_core #(.N(N), .W(W), .ACCW(ACCW), .SIGNED(1)) dut_s (
    .i_clk(clk), .i_arst(arst), .i_a(a), .i_b(b), .i_validInput(valid),
    .o_ready(rdy_s), .o_c(c_s), .o_validResult(vld_s));

  function automatic mat_c_t model(input mat_t x, input mat_t y, input bit sgn);
    mat_c_t r;
    longint s;
    r = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) begin
          if (sgn) s += longint'($signed(x[i][k])) * longint'($signed(y[k][j]));
          else     s += longint'(x[i][k]) * longint'(y[k][j]);
        end
        r[i][j] = s[ACCW-1:0];
      end
    end
    return r;
  endfunction

  function automatic mat_t fill(input int v);
    mat_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) r[i][j] = W'(v);
    return r;
  endfunction

  function automatic mat_t rnd();
    mat_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) r[i][j] = W'($urandom_range(0, (1 << W) - 1));
    return r;
  endfunction

  function automatic mat_t ident();
    mat_t r;
    r = '0;
    for (int i = 0; i < N; i++) r[i][i] = W'(1);
    return r;
  endfunction

  function automatic mat_t seq();
    mat_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) r[i][j] = W'(N*i + j + 1);
    return r;
  endfunction

  task automatic chk_bit(input string tag, input logic obs, input logic expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: observed %b expected %b", tag, cyc, obs, expv);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: observed %0d expected %0d", tag, cyc, obs, expv);
    end
  endtask

  task automatic chk_el(input string tag, input logic [ACCW-1:0] obs, input logic [ACCW-1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, expv);
    end
  endtask

  task automatic chk_mat(input string tag, input mat_c_t obs, input mat_c_t expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, expv);
    end
  endtask

  // One clock: predict accept/completion, advance, then check every output against the model.
  task automatic tick();
    bit acc_now, done;
    acc_now = (valid === 1'b1) && (rem == 0);
    done    = 1'b0;
    if (acc_now) begin
      q_u.push_back(model(a, b, 1'b0));
      q_s.push_back(model(a, b, 1'b1));
      rem = LAT;
    end else if (rem > 0) begin
      rem--;
      done = (rem == 0);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (vld_u === 1'b1) pulse_cnt++;
    if (done) begin
      chk_int("sb_nonempty", int'(q_u.size() > 0 && q_s.size() > 0), 1);
      if (q_u.size() > 0) exp_cu = q_u.pop_front();
      if (q_s.size() > 0) exp_cs = q_s.pop_front();
    end
    chk_bit("ready_u", rdy_u, rem == 0);
    chk_bit("ready_s", rdy_s, rem == 0);
    chk_bit("valid_u", vld_u, done);
    chk_bit("valid_s", vld_s, done);
    chk_mat("c_u", c_u, exp_cu);
    chk_mat("c_s", c_s, exp_cs);
  endtask

  task automatic rst_checks(input string tag);
    chk_mat({tag, "_c_u"}, c_u, '0);
    chk_mat({tag, "_c_s"}, c_s, '0);
    chk_bit({tag, "_ready_u"}, rdy_u, 1'b1);
    chk_bit({tag, "_ready_s"}, rdy_s, 1'b1);
    chk_bit({tag, "_valid_u"}, vld_u, 1'b0);
    chk_bit({tag, "_valid_s"}, vld_s, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; the in-flight run is abandoned.
  task automatic apply_reset();
    #2;
    arst = 1'b1;
    #1;
    rst_checks("abort_rst");
    q_u.delete();
    q_s.delete();
    rem    = 0;
    exp_cu = '0;
    exp_cs = '0;
    @(posedge clk);
    #1;
    cyc++;
    arst = 1'b0;
  endtask

  // Accept one matrix pair, scramble the inputs, and measure accept-to-result latency.
  task automatic run_one(input mat_t x, input mat_t y);
    int n;
    a = x;
    b = y;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    a = rnd();
    b = rnd();
    n = 0;
    while (vld_u !== 1'b1 && n < 4*LAT) begin
      tick();
      n++;
    end
    chk_int("latency", n, LAT);
  endtask

  initial begin
    int p0;
    int pc[$];

    #1 arst = 1'b1;
    #1 rst_checks("reset");
    @(posedge clk);
    #1;
    arst = 1'b0;
    tick();

    // Identity times a counting matrix returns the counting matrix.
    run_one(ident(), seq());
    chk_el("ident_c32", c_u[3][2], ACCW'(15));
    chk_el("ident_c00", c_u[0][0], ACCW'(1));
    tick();

    // Largest unsigned operands: needs the full accumulator width.
    run_one(fill(255), fill(255));
    chk_el("max_u_c33", c_u[3][3], ACCW'(260100));
    tick();

    // Most negative times most positive, then most negative squared.
    run_one(fill(8'h80), fill(8'h7f));
    chk_el("neg_pos_s", c_s[1][2], ACCW'(-65024));
    chk_el("neg_pos_u", c_u[1][2], ACCW'(65024));
    tick();
    run_one(fill(8'h80), fill(8'h80));
    chk_el("neg_neg_s", c_s[2][1], ACCW'(65536));
    tick();

    // Requests while busy are ignored; the result reflects the first pair.
    p0 = pulse_cnt;
    a = rnd();
    b = rnd();
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (3) tick();
    a = rnd();
    b = rnd();
    valid = 1'b1;
    repeat (2) tick();
    valid = 1'b0;
    for (int n = 0; n < 4*LAT && rem != 0; n++) tick();
    chk_int("ignore_pulses", pulse_cnt - p0, 1);
    tick();

    // Back-to-back: request held high while inputs change every cycle.
    valid = 1'b1;
    for (int n = 0; n < 3*(LAT+1) + 3; n++) begin
      a = rnd();
      b = rnd();
      tick();
      if (vld_u === 1'b1) pc.push_back(cyc);
    end
    valid = 1'b0;
    for (int n = 0; n < 4*LAT && rem != 0; n++) tick();
    chk_int("b2b_pulses", pc.size(), 3);
    if (pc.size() >= 3) begin
      chk_int("b2b_gap1", pc[1] - pc[0], LAT + 1);
      chk_int("b2b_gap2", pc[2] - pc[1], LAT + 1);
    end
    tick();

    // Reset five cycles into a run: no result, then a clean run afterwards.
    a = fill(200);
    b = fill(100);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (5) tick();
    apply_reset();
    p0 = pulse_cnt;
    repeat (3*N + 3) tick();
    chk_int("abort_no_pulse", pulse_cnt - p0, 0);
    run_one(rnd(), rnd());
    tick();
    run_one(seq(), ident());
    chk_el("post_rst_c13", c_u[1][3], ACCW'(N + 4));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
